// File: rtl/vga_timing_gen.sv
// Raster timing generator for the 640x480 @ 60 Hz VGA path (DrawX/DrawY/blank, hs/vs, frame_start).
// Optional frame counter output enabled by defining VGA_FRAME_CNT_EN.
module vga_timing_gen #(
    parameter int H_VISIBLE  = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_VISIBLE  = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter int SYNC_DELAY = 2
) (
    input  logic        vga_clk,
    input  logic        reset_n,
    output logic [9:0]  DrawX,
    output logic [9:0]  DrawY,
    output logic        blank,
    output logic        hs,
    output logic        vs,
    output logic        frame_start
`ifdef VGA_FRAME_CNT_EN
    ,
    output logic [15:0] frame_count
`endif
);

    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
    localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FP + H_SYNC);
    localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FP + V_SYNC);

    logic [9:0] x_nxt;
    logic [9:0] y_nxt;
    logic       blank_nxt;
    logic       hs_raw_nxt;
    logic       vs_raw_nxt;
    logic       fs_nxt;
    logic       hs_raw;
    logic       vs_raw;

    // Every registered output is decoded from the next-state counters so it
    // lines up with DrawX/DrawY in the same cycle.
    always_comb begin
        x_nxt = DrawX + 10'd1;
        y_nxt = DrawY;
        if (DrawX == H_LAST) begin
            x_nxt = '0;
            y_nxt = (DrawY == V_LAST) ? '0 : DrawY + 10'd1;
        end
        blank_nxt  = (x_nxt < H_VIS) && (y_nxt < V_VIS);
        hs_raw_nxt = !((x_nxt >= HS_START) && (x_nxt < HS_END));
        vs_raw_nxt = !((y_nxt >= VS_START) && (y_nxt < VS_END));
        fs_nxt     = (x_nxt == '0) && (y_nxt == '0);
    end

    // Free-running: no valid/ready handshake, state advances on every vga_clk.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            DrawX       <= H_LAST;
            DrawY       <= V_LAST;
            blank       <= 1'b0;
            hs_raw      <= 1'b1;
            vs_raw      <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            DrawX       <= x_nxt;
            DrawY       <= y_nxt;
            blank       <= blank_nxt;
            hs_raw      <= hs_raw_nxt;
            vs_raw      <= vs_raw_nxt;
            frame_start <= fs_nxt;
        end
    end

    // Sync delay line keeps hs/vs aligned with the mapper's registered RGB.
    generate
        if (SYNC_DELAY == 0) begin : g_no_dly
            assign hs = hs_raw;
            assign vs = vs_raw;
        end else begin : g_dly
            logic [1:0] sync_pipe [SYNC_DELAY];

            always_ff @(posedge vga_clk or negedge reset_n) begin
                if (!reset_n) begin
                    for (int i = 0; i < SYNC_DELAY; i++) begin
                        sync_pipe[i] <= 2'b11;
                    end
                end else begin
                    sync_pipe[0] <= {hs_raw, vs_raw};
                    for (int i = 1; i < SYNC_DELAY; i++) begin
                        sync_pipe[i] <= sync_pipe[i-1];
                    end
                end
            end

            assign hs = sync_pipe[SYNC_DELAY-1][1];
            assign vs = sync_pipe[SYNC_DELAY-1][0];
        end
    endgenerate

`ifdef VGA_FRAME_CNT_EN
    // Starts at all-ones so the first frame_start edge brings it to 0.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            frame_count <= 16'hFFFF;
        end else if (fs_nxt) begin
            frame_count <= frame_count + 16'd1;
        end
    end
`endif

endmodule
